bus_master_interface: RTL and testbench
=======================================

# bus_master_interface

Initiator side of the shared system bus (addr_bus/data_bus/rd_bus/wr_bus/data_mask_bus/fc_bus). It accepts one load/store request at a time from a core-side valid/ready port and runs the bus handshake against any memory-mapped device. It waits for fc_bus with a timeout, then returns sign- or zero-extended read data or a write acknowledgement. It is the single bus master; every device bus interface is a responder to it.

## Interface
- TIMEOUT_CYCLES, 256: maximum cycles a strobe is held without fc_bus before the access aborts with error.
- clk  in  1  system clock.
- rst  in  1  one clock; reset is asynchronous and active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  high exactly when state is IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend load result.
- resp_valid  out  1  one-cycle pulse, response valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size or timeout.
- addr_bus  out  32  bus address.
- data_bus  inout  32  driven only while wr_bus is high; 'z otherwise.
- rd_bus, wr_bus  out  1  read and write strobes, never both high.
- data_mask_bus  out  4  low-aligned byte mask: 4'b0001, 4'b0011 or 4'b1111. The responder shifts it by addr[1:0].
- fc_bus  in  1  function complete, tri-stated by unaddressed devices. Only a value of exactly 1 counts as asserted; 0, z and x count as not asserted.

## Operation
- States: IDLE, READ, WRITE, RELEASE.
- IDLE: on req_valid, latch addr, wdata, size, signed and write.
  - Alignment check: a half requires addr[0]=0; a word requires addr[1:0]=0.
  - Illegal size or misalignment → RELEASE with err=1. No strobe is raised.
  - Otherwise → READ or WRITE. Drive addr_bus and data_mask_bus, clear the timeout counter.
- READ: rd_bus=1. On an edge with fc_bus=1, capture data_bus and → RELEASE.
  - Responder read data is low-aligned.
  - Extend by size: byte uses [7:0], half uses [15:0], each sign- or zero-extended per req_signed; word is passed unchanged.
- WRITE: wr_bus=1, data_bus=latched wdata. On an edge with fc_bus=1 → RELEASE.
- Timeout: in READ/WRITE the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no fc_bus → RELEASE with err=1, rdata=0.
- RELEASE: strobes low, data_bus 'z, resp_valid=1 for this single cycle → IDLE.
  - This cycle lets a responder's write-done state return to idle before the next access.
- addr_bus and data_mask_bus hold their last values between accesses. Responders ignore them without a strobe.
- Reset values (asynchronous, while rst=0):
  - state=IDLE, rd_bus=0, wr_bus=0, addr_bus=0, data_mask_bus=0, data_bus='z.
  - resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - Reset mid-access drops strobes immediately; no response is produced.

## Timing
- Accept edge E0. Strobes are registered and asserted in the cycle after E0.
- Read with a combinational responder:
  - rd_bus high in cycle 1; fc is sampled at E1.
  - resp_valid in cycle 2; req_ready in cycle 3.
  - Request-to-response latency is 2 cycles.
- Write with a registered responder:
  - wr_bus high in cycles 1–2; the responder commits at E1 and raises fc in cycle 2.
  - RELEASE and resp_valid in cycle 3; req_ready in cycle 4.
- Error without a bus cycle: resp_valid in cycle 1.
- Timeout: strobe held exactly TIMEOUT_CYCLES cycles; resp_valid the following cycle.
- Back-to-back requests: minimum one RELEASE plus one IDLE cycle between strobe windows.
- fc_bus and timeout expiry on the same edge: fc_bus wins and err=0.

## Structure
- Package bus_pkg:
  - size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - Mask constants MASK_BYTE/MASK_HALF/MASK_WORD.
  - State enum.
  - size-to-mask and alignment-check functions.
- Sub-module bus_read_extender: combinational extension of captured data by size and sign. Shared with future masters such as DMA.
- The top module holds the FSM, the counter, the latched request and the tri-state driver.

## Test plan
- Word write 0xDEADBEEF to 0x1000 (registered responder model):
  - wr_bus high exactly 2 cycles, data_mask_bus=4'b1111.
  - resp_valid in cycle 3 with err=0; slave register = 0xDEADBEEF.
- Signed byte load from 0x2003; responder returns 0x000000F0 → resp_rdata=0xFFFFFFF0. Unsigned → 0x000000F0. data_mask_bus=4'b0001, latency 2.
- Half load at 0x2001 → resp_err=1 one cycle after accept, rd_bus never asserted. req_size=3 → same.
- No responder (fc_bus='z), TIMEOUT_CYCLES=8:
  - rd_bus high 8 cycles, then resp_valid with err=1, rdata=0.
  - The next request is accepted normally.
- rst low while wr_bus is high: wr_bus=0 and data_bus='z immediately, no resp_valid. After release, a new word read returns the correct data.
- fc_bus asserted on the same edge the timeout expires (TIMEOUT_CYCLES=4, fc in cycle 4) → err=0 and read data is captured.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the system bus: access sizes, byte masks,
// master FSM states and the size/alignment rules used by every bus master.
package bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RELEASE
  } state_e;

  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return MASK_BYTE;
      SIZE_HALF: return MASK_HALF;
      SIZE_WORD: return MASK_WORD;
      default:   return 4'b0000;
    endcase
  endfunction

  // Legal size and naturally aligned; size 3 is never legal.
  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_read_extender.sv
// Sign/zero extension of low-aligned bus read data by access size.
// Kept separate so other masters (e.g. DMA) can reuse it.
module bus_read_extender
  import bus_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SIZE_BYTE: data = {{24{is_signed & raw[7]}}, raw[7:0]};
      SIZE_HALF: data = {{16{is_signed & raw[15]}}, raw[15:0]};
      default:   data = raw;
    endcase
  end

endmodule

// File: rtl/bus_master_interface.sv
// Single initiator on the shared system bus: accepts one core load/store at a
// time, runs the rd/wr strobe handshake with an fc_bus timeout, returns a response.
module bus_master_interface
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_bus,
  inout  tri   [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e      state, state_next;
  logic [CW-1:0] count;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] raw_q;
  logic        err_q;
  logic        fc_hit;
  logic        expired;
  logic        req_ok;

  // z and x on fc_bus must not count as completion.
  assign fc_hit  = (fc_bus == 1'b1);
  assign expired = (count == COUNT_LAST);
  assign req_ok  = access_ok(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_ok)        state_next = ST_RELEASE;
          else if (req_write) state_next = ST_WRITE;
          else                state_next = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (fc_hit || expired) state_next = ST_RELEASE;
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    rd_bus     = (state == ST_READ);
    wr_bus     = (state == ST_WRITE);
    resp_valid = (state == ST_RELEASE);
    resp_err   = (state == ST_RELEASE) && err_q;
  end

  // raw_q is cleared on accept so stores and errors read back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count         <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      raw_q         <= '0;
      err_q         <= 1'b0;
      addr_bus      <= '0;
      data_mask_bus <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            signed_q <= req_signed;
            raw_q    <= '0;
            count    <= '0;
            err_q    <= ~req_ok;
            if (req_ok) begin
              addr_bus      <= req_addr;
              data_mask_bus <= size_to_mask(req_size);
            end
          end
        end
        ST_READ: begin
          if (fc_hit)       raw_q <= data_bus;
          else if (expired) err_q <= 1'b1;
          else              count <= count + 1'b1;
        end
        ST_WRITE: begin
          if (!fc_hit) begin
            if (expired) err_q <= 1'b1;
            else         count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_bus = wr_bus ? wdata_q : 'z;

  bus_read_extender u_extender (
    .raw       (raw_q),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (resp_rdata)
  );

endmodule

// File: tb/tb_bus_master_interface.sv
// Directed vector bench for bus_master_interface with a simple responder model
// whose fc_bus delay (or absence) is set per vector.
module tb_bus_master_interface;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, addr_bus;
  logic        rd_bus, wr_bus;
  logic [3:0]  data_mask_bus;
  wire  [31:0] data_bus;
  wire         fc_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_master_interface #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .rd_bus        (rd_bus),
    .wr_bus        (wr_bus),
    .data_mask_bus (data_mask_bus),
    .fc_bus        (fc_bus)
  );

  // Responder: fc rises fc_delay cycles into a strobe; writes commit at the first strobe edge.
  logic        fc_on = 1'b0;
  int unsigned fc_delay = 0;
  logic [31:0] dev_rdata = '0;
  logic [31:0] slave_reg = '0;
  int unsigned strobe_cnt = 0;
  logic        fc_val;

  assign fc_val   = (rd_bus || wr_bus) && (strobe_cnt >= fc_delay);
  assign fc_bus   = fc_on ? fc_val : 1'bz;
  assign data_bus = (fc_on && rd_bus) ? dev_rdata : 'z;

  always @(posedge clk) begin
    if (rd_bus || wr_bus) strobe_cnt <= strobe_cnt + 1;
    else                  strobe_cnt <= 0;
    if (wr_bus && fc_on && strobe_cnt == 0) slave_reg <= data_bus;
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic        resp_on;
    int unsigned fc_delay;
    logic [31:0] dev;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
    int unsigned exp_strobes;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic s, input logic on,
                              input int unsigned d, input logic [31:0] dev,
                              input logic e, input logic [31:0] rd,
                              input int unsigned lat, input int unsigned strb);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.size = sz; v.sgn = s;
    v.resp_on = on; v.fc_delay = d; v.dev = dev;
    v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat; v.exp_strobes = strb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat = 0, rd_n = 0, wr_n = 0;
    logic        both = 1'b0;
    logic [31:0] s_addr = '0, s_data = '0, got_rdata = '0;
    logic [3:0]  s_mask = '0, exp_mask;
    logic        got_err = 1'b0;
    case (v.size)
      2'd0:    exp_mask = 4'b0001;
      2'd1:    exp_mask = 4'b0011;
      default: exp_mask = 4'b1111;
    endcase
    fc_on = v.resp_on; fc_delay = v.fc_delay; dev_rdata = v.dev;
    @(negedge clk);
    wait_ready(tag);
    req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_signed = v.sgn; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= int'(T) + 5; k++) begin
      @(negedge clk);
      if (rd_bus) rd_n++;
      if (wr_bus) wr_n++;
      if (rd_bus && wr_bus) both = 1'b1;
      if (rd_bus || wr_bus) begin
        s_addr = addr_bus; s_mask = data_mask_bus;
        if (wr_bus) s_data = data_bus;
      end
      if (resp_valid) begin
        lat = k; got_err = resp_err; got_rdata = resp_rdata;
        break;
      end
    end
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " err"}, 32'(got_err), 32'(v.exp_err));
    check({tag, " rdata"}, got_rdata, v.exp_rdata);
    check({tag, " both strobes"}, 32'(both), 32'd0);
    check({tag, " rd cycles"}, rd_n, v.write ? 0 : v.exp_strobes);
    check({tag, " wr cycles"}, wr_n, v.write ? v.exp_strobes : 0);
    if (v.exp_strobes > 0) begin
      check({tag, " addr_bus"}, s_addr, v.addr);
      check({tag, " mask"}, 32'(s_mask), 32'(exp_mask));
      if (v.write) check({tag, " data_bus"}, s_data, v.wdata);
    end
    if (v.write && !v.exp_err) check({tag, " slave_reg"}, slave_reg, v.wdata);
    @(negedge clk);
    check({tag, " pulse end"}, 32'(resp_valid), 32'd0);
    check({tag, " ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h1000, 32'hDEADBEEF, 2, 0, 1, 1, 0, 0, 32'h0, 3, 2);
    vecs[1]  = mk(0, 32'h2003, 0, 0, 1, 1, 0, 32'h000000F0, 0, 32'hFFFFFFF0, 2, 1);
    vecs[2]  = mk(0, 32'h2003, 0, 0, 0, 1, 0, 32'h000000F0, 0, 32'h000000F0, 2, 1);
    vecs[3]  = mk(0, 32'h2001, 0, 1, 0, 1, 0, 32'h12345678, 1, 32'h0, 1, 0);
    vecs[4]  = mk(0, 32'h2000, 0, 3, 0, 1, 0, 32'h12345678, 1, 32'h0, 1, 0);
    vecs[5]  = mk(0, 32'h2002, 0, 1, 1, 1, 0, 32'h00008001, 0, 32'hFFFF8001, 2, 1);
    vecs[6]  = mk(0, 32'h2002, 0, 1, 0, 1, 0, 32'h12348001, 0, 32'h00008001, 2, 1);
    vecs[7]  = mk(0, 32'h3000, 0, 2, 1, 1, 0, 32'h80000001, 0, 32'h80000001, 2, 1);
    vecs[8]  = mk(0, 32'h4000, 0, 2, 0, 0, 0, 32'hAAAA5555, 1, 32'h0, T + 1, T);
    vecs[9]  = mk(0, 32'h0, 0, 2, 0, 1, 0, 32'h01020304, 0, 32'h01020304, 2, 1);
    vecs[10] = mk(0, 32'h5000, 0, 2, 0, 1, T - 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, T + 1, T);
    vecs[11] = mk(0, 32'h5004, 0, 2, 0, 1, T, 32'hCAFEF00D, 1, 32'h0, T + 1, T);
    vecs[12] = mk(0, 32'h6001, 0, 0, 1, 1, 0, 32'h0000007F, 0, 32'h0000007F, 2, 1);
    vecs[13] = mk(1, 32'h1002, 32'hFFFFABCD, 1, 0, 1, 0, 0, 0, 32'h0, 2, 1);
    vecs[14] = mk(1, 32'h1006, 32'h11223344, 2, 0, 1, 0, 0, 1, 32'h0, 1, 0);

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_signed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset rd_bus", 32'(rd_bus), 32'd0);
    check("reset wr_bus", 32'(wr_bus), 32'd0);
    check("reset addr_bus", addr_bus, 32'd0);
    check("reset mask", 32'(data_mask_bus), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted while a write strobe is active.
    fc_on = 1'b0;
    @(negedge clk);
    wait_ready("rstmid");
    req_write = 1'b1; req_addr = 32'h7000; req_wdata = 32'h11111111;
    req_size = 2'd2; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid wr before", 32'(wr_bus), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid wr_bus", 32'(wr_bus), 32'd0);
    check("rstmid rd_bus", 32'(rd_bus), 32'd0);
    check("rstmid addr_bus", addr_bus, 32'd0);
    check("rstmid ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid no resp", 32'(resp_valid), 32'd0);
    end
    rst = 1'b1;
    run_vec(mk(0, 32'h7000, 0, 2, 0, 1, 0, 32'h5A5AA5A5, 0, 32'h5A5AA5A5, 2, 1), "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
